// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared constants for the multi-cycle MIPS main control:
//   FSM state encodings, opcode/funct values, 4-bit ALU_Cntrl codes,
//   and the ALUSrcB / PCSrc select values.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MEMADR = 4'h2,
    S_MEMRD  = 4'h3,
    S_MEMWB  = 4'h4,
    S_MEMWR  = 4'h5,
    S_EXEC   = 4'h6,
    S_ALUWB  = 4'h7,
    S_BRANCH = 4'h8,
    S_IEXEC  = 4'h9,
    S_IWB    = 4'hA,
    S_JUMP   = 4'hB
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU_Cntrl codes
  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_NOR  = 4'h4;
  localparam logic [3:0] ALU_SLTU = 4'h5;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLLV = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRLV = 4'hB;
  localparam logic [3:0] ALU_SRA  = 4'hC;
  localparam logic [3:0] ALU_SRAV = 4'hD;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// alu_control_decoder
//   Combinational R-type funct decode into the 4-bit ALU operation code.
//   Ports:
//     i_funct        in  6  instruction bits [5:0]
//     o_alu_cntrl    out 4  ALU operation code (ADD for unmapped funct)
//     o_funct_valid  out 1  funct is a supported R-type operation
module alu_control_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_cntrl,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_cntrl   = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      F_ADD, F_ADDU: o_alu_cntrl = ALU_ADD;
      F_SUB, F_SUBU: o_alu_cntrl = ALU_SUB;
      F_AND:         o_alu_cntrl = ALU_AND;
      F_OR:          o_alu_cntrl = ALU_OR;
      F_XOR:         o_alu_cntrl = ALU_XOR;
      F_NOR:         o_alu_cntrl = ALU_NOR;
      F_SLT:         o_alu_cntrl = ALU_SLT;
      F_SLTU:        o_alu_cntrl = ALU_SLTU;
      F_SLL:         o_alu_cntrl = ALU_SLL;
      F_SRL:         o_alu_cntrl = ALU_SRL;
      F_SRA:         o_alu_cntrl = ALU_SRA;
      F_SLLV:        o_alu_cntrl = ALU_SLLV;
      F_SRLV:        o_alu_cntrl = ALU_SRLV;
      F_SRAV:        o_alu_cntrl = ALU_SRAV;
      default:       o_funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_main_control.sv
// multi_cycle_main_control
//   Main control FSM of the multi-cycle MIPS datapath. Decodes Opcode/Funct,
//   sequences fetch/decode/execute/writeback and drives datapath selects,
//   write enables and the ALU operation code.
//   Optional feature macro: OVF_WB_SUPPRESS_EN (signed-overflow writeback
//   suppression for add/sub/addi).
//   Ports:
//     CLK, RST            clock, synchronous active-high reset
//     Opcode, Funct       instruction fields from the IR
//     ZF_IN, OF_IN        ALU zero / overflow flags
//     IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//     ALUSrcB, ALU_Cntrl, ExtSel, PCSrc, PCEn   datapath controls
//     IllegalOp           pulse in DECODE for unsupported opcode/funct
//     State_OUT           current state (debug)
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4
//   DECODE | compute branch target, dispatch on opcode
//   MEMADR | ALUOut <= A + sign-ext imm (lw/sw address)
//   MEMRD  | read data memory at ALUOut
//   MEMWB  | rt <= MDR
//   MEMWR  | write B to data memory at ALUOut
//   EXEC   | R-type ALU op on A, B
//   ALUWB  | rd <= ALUOut
//   BRANCH | compare A-B, load PC with target when zero
//   IEXEC  | immediate ALU op on A, ext imm
//   IWB    | rt <= ALUOut
//   JUMP   | PC <= jump target
module multi_cycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic                   ZF_IN,
  input  logic                   OF_IN,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [3:0]             ALU_Cntrl,
  output logic                   ExtSel,
  output logic [1:0]             PCSrc,
  output logic                   PCEn,
  output logic                   IllegalOp,
  output logic [STATE_WIDTH-1:0] State_OUT
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_funct_alu;
  logic       w_funct_valid;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_wb_ok;

  alu_control_decoder u_alu_dec (
    .i_funct       (Funct),
    .o_alu_cntrl   (w_funct_alu),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

`ifdef OVF_WB_SUPPRESS_EN
  logic r_ovf;

  // Only the trapping adds/subs capture overflow; every other edge clears it,
  // so the flag is live exactly during the following writeback state.
  always_ff @(posedge CLK) begin
    if (RST)
      r_ovf <= 1'b0;
    else if (r_state == S_EXEC && (Funct == F_ADD || Funct == F_SUB))
      r_ovf <= OF_IN;
    else if (r_state == S_IEXEC && Opcode == OP_ADDI)
      r_ovf <= OF_IN;
    else
      r_ovf <= 1'b0;
  end

  assign w_wb_ok = ~r_ovf;
`else
  logic w_unused_of_in;
  assign w_unused_of_in = OF_IN;
  assign w_wb_ok        = 1'b1;
`endif

  always_comb begin
    w_next_state = S_FETCH;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    ALU_Cntrl    = ALU_ADD;
    ExtSel       = 1'b0;
    PCSrc        = PC_ALU;
    IllegalOp    = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;

    case (r_state)
      S_FETCH: begin
        IRWrite      = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        if (Opcode == OP_LW || Opcode == OP_SW)
          w_next_state = S_MEMADR;
        else if (Opcode == OP_RTYPE && w_funct_valid)
          w_next_state = S_EXEC;
        else if (Opcode == OP_BEQ)
          w_next_state = S_BRANCH;
        else if (is_imm_alu(Opcode))
          w_next_state = S_IEXEC;
        else if (Opcode == OP_J)
          w_next_state = S_JUMP;
        else
          IllegalOp = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        w_next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD         = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA      = 1'b1;
        ALU_Cntrl    = w_funct_alu;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = w_wb_ok;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALU_Cntrl = ALU_SUB;
        PCSrc     = PC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        w_next_state = S_IWB;
        case (Opcode)
          OP_ANDI: begin
            ALU_Cntrl = ALU_AND;
            ExtSel    = 1'b1;
          end
          OP_ORI: begin
            ALU_Cntrl = ALU_OR;
            ExtSel    = 1'b1;
          end
          OP_SLTI: ALU_Cntrl = ALU_SLT;
          default: ALU_Cntrl = ALU_ADD;
        endcase
      end
      S_IWB: begin
        RegWrite = w_wb_ok;
      end
      S_JUMP: begin
        PCSrc      = PC_JUMP;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase

    // Reset must never let a write or a PC/IR load escape, whatever the
    // state register currently holds.
    if (RST) begin
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
    PCEn = (w_pc_write | (w_branch & ZF_IN)) & ~RST;
  end

  assign State_OUT = STATE_WIDTH'(r_state);

endmodule

// File: tb/tb_multi_cycle_main_control.sv
module tb_multi_cycle_main_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       ZF_IN = 1'b0;
  logic       OF_IN = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALU_Cntrl;
  logic       ExtSel;
  logic [1:0] PCSrc;
  logic       PCEn, IllegalOp;
  logic [3:0] State_OUT;

  int n_pass  = 0;
  int n_total = 0;

  multi_cycle_main_control #(.STATE_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
    .ZF_IN(ZF_IN), .OF_IN(OF_IN),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Cntrl(ALU_Cntrl), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .PCEn(PCEn), .IllegalOp(IllegalOp), .State_OUT(State_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // R-type: starts in FETCH, ends in FETCH
  task automatic run_rtype(input logic [5:0] fn, input logic [3:0] exp_alu);
    Opcode = 6'h00; Funct = fn;
    tick(); check("r_dec_st", 32'(State_OUT), 1); check("r_dec_ill", 32'(IllegalOp), 0);
    tick(); check("r_exec_st", 32'(State_OUT), 6); check("r_exec_alu", 32'(ALU_Cntrl), 32'(exp_alu));
    check("r_exec_srcb", 32'(ALUSrcB), 0);
    tick(); check("r_wb_st", 32'(State_OUT), 7); check("r_wb_regdst", 32'(RegDst), 1);
    check("r_wb_regwr", 32'(RegWrite), 1);
    tick(); check("r_end_st", 32'(State_OUT), 0);
  endtask

  task automatic run_beq(input logic zf);
    Opcode = 6'h04;
    tick(); check("beq_dec_st", 32'(State_OUT), 1);
    tick(); ZF_IN = zf; #1;
    check("beq_st", 32'(State_OUT), 8); check("beq_pcen", 32'(PCEn), 32'(zf));
    check("beq_pcsrc", 32'(PCSrc), 1); check("beq_alu", 32'(ALU_Cntrl), 6);
    tick(); ZF_IN = 1'b0;
    check("beq_end_st", 32'(State_OUT), 0);
  endtask

  task automatic run_addi(input logic of, input logic exp_wr);
    Opcode = 6'h08;
    tick(); check("addi_dec_st", 32'(State_OUT), 1);
    tick(); OF_IN = of; #1;
    check("addi_iexec_st", 32'(State_OUT), 9); check("addi_alu", 32'(ALU_Cntrl), 2);
    check("addi_ext", 32'(ExtSel), 0);
    tick(); OF_IN = 1'b0;
    check("addi_iwb_st", 32'(State_OUT), 10); check("addi_regwr", 32'(RegWrite), 32'(exp_wr));
    check("addi_regdst", 32'(RegDst), 0);
    tick(); check("addi_end_st", 32'(State_OUT), 0);
  endtask

  logic exp_ovf_wr;

  initial begin
`ifdef OVF_WB_SUPPRESS_EN
    exp_ovf_wr = 1'b0;
`else
    exp_ovf_wr = 1'b1;
`endif
    // reset held two cycles with a lw opcode on the bus
    RST = 1'b1; Opcode = 6'h23;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_irwrite", 32'(IRWrite), 0); check("rst_pcen", 32'(PCEn), 0);
      check("rst_memwr", 32'(MemWrite), 0); check("rst_regwr", 32'(RegWrite), 0);
    end
    RST = 1'b0; #1;
    check("rel_st", 32'(State_OUT), 0); check("rel_irwrite", 32'(IRWrite), 1);
    check("rel_alu", 32'(ALU_Cntrl), 2); check("rel_srcb", 32'(ALUSrcB), 1);
    check("rel_pcen", 32'(PCEn), 1);

    // lw: 0,1,2,3,4,0
    tick(); check("lw_st1", 32'(State_OUT), 1); check("lw_dec_srcb", 32'(ALUSrcB), 3);
    check("lw_regwr1", 32'(RegWrite), 0);
    tick(); check("lw_st2", 32'(State_OUT), 2); check("lw_adr_srca", 32'(ALUSrcA), 1);
    check("lw_adr_srcb", 32'(ALUSrcB), 2); check("lw_regwr2", 32'(RegWrite), 0);
    tick(); check("lw_st3", 32'(State_OUT), 3); check("lw_iord", 32'(IorD), 1);
    check("lw_m2r3", 32'(MemtoReg), 0); check("lw_regwr3", 32'(RegWrite), 0);
    tick(); check("lw_st4", 32'(State_OUT), 4); check("lw_m2r4", 32'(MemtoReg), 1);
    check("lw_regwr4", 32'(RegWrite), 1); check("lw_regdst4", 32'(RegDst), 0);
    tick(); check("lw_st0", 32'(State_OUT), 0); check("lw_regwr0", 32'(RegWrite), 0);

    // sw: 0,1,2,5,0
    Opcode = 6'h2B;
    tick(); tick(); check("sw_st2", 32'(State_OUT), 2);
    tick(); check("sw_st5", 32'(State_OUT), 5); check("sw_memwr", 32'(MemWrite), 1);
    check("sw_iord", 32'(IorD), 1);
    tick(); check("sw_st0", 32'(State_OUT), 0); check("sw_memwr0", 32'(MemWrite), 0);

    run_rtype(6'h22, 4'h6);
    run_rtype(6'h07, 4'hD);
    run_rtype(6'h2B, 4'h5);
    run_rtype(6'h27, 4'h4);

    run_beq(1'b1);
    run_beq(1'b0);

    // jump
    Opcode = 6'h02;
    tick(); tick();
    check("j_st", 32'(State_OUT), 11); check("j_pcsrc", 32'(PCSrc), 2);
    check("j_pcen", 32'(PCEn), 1);
    tick(); check("j_end_st", 32'(State_OUT), 0);

    // andi uses zero extension and AND
    Opcode = 6'h0C;
    tick(); tick();
    check("andi_st", 32'(State_OUT), 9); check("andi_alu", 32'(ALU_Cntrl), 0);
    check("andi_ext", 32'(ExtSel), 1);
    tick(); check("andi_regwr", 32'(RegWrite), 1);
    tick(); check("andi_end_st", 32'(State_OUT), 0);

    // illegal opcode
    Opcode = 6'h3F;
    tick(); check("ill_op_st", 32'(State_OUT), 1); check("ill_op_pulse", 32'(IllegalOp), 1);
    tick(); check("ill_op_next", 32'(State_OUT), 0); check("ill_op_clear", 32'(IllegalOp), 0);

    // illegal funct
    Opcode = 6'h00; Funct = 6'h3F;
    tick(); check("ill_fn_st", 32'(State_OUT), 1); check("ill_fn_pulse", 32'(IllegalOp), 1);
    check("ill_fn_regwr", 32'(RegWrite), 0);
    tick(); check("ill_fn_next", 32'(State_OUT), 0); check("ill_fn_regwr0", 32'(RegWrite), 0);

    // addi overflow handling
    run_addi(1'b1, exp_ovf_wr);
    run_addi(1'b0, 1'b1);

    // reset asserted mid-run from DECODE
    Opcode = 6'h23;
    tick(); check("mid_st", 32'(State_OUT), 1);
    RST = 1'b1;
    tick(); check("mid_rst_st", 32'(State_OUT), 0); check("mid_rst_ir", 32'(IRWrite), 0);
    check("mid_rst_pcen", 32'(PCEn), 0);
    RST = 1'b0; #1;
    check("mid_rel_ir", 32'(IRWrite), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
